// File: rtl/dispense_sequencer.sv
// ---------------------------------------------------------------------------
// dispense_sequencer
//
// Purpose:
//   Dispense controller for the candy/snack machine. A dispense request comes
//   in on the rising edge of `go`. The controller steps the carousel stepper to
//   the selected slot. It waits for the carousel to settle, then pulses the DC
//   motor of that channel once per requested item, with an off gap between
//   items. `abort` cancels an operation at any point. The stepper position is
//   tracked to the single step, so a cancelled move needs no homing.
//
// Ports:
//   clk_x1    in   1        system clock (12 MHz nominal)
//   rstn      in   1        asynchronous active-low reset
//   go        in   1        dispense request; rising edge accepted in idle only
//   abort     in   1        level; cancels the operation in progress
//   sel       in   CH_W     target channel / carousel slot
//   amount    in   AMT_W    number of items to dispense
//   step      out  1        stepper step pulse, one cycle wide
//   dir       out  1        stepper direction, 1 = towards higher slot index
//   dc_en     out  NUM_CH   one-hot DC motor enables
//   busy      out  1        operation in progress
//   done      out  1        one-cycle completion pulse
//   err       out  1        one-cycle pulse on a request for a missing slot
//   cur_slot  out  CH_W     slot reached by the last completed move
// ---------------------------------------------------------------------------
module dispense_sequencer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned AMT_W          = 2,
    parameter int unsigned STEP_DIV       = 12000,
    parameter int unsigned STEPS_PER_SLOT = 50,
    parameter int unsigned SETTLE         = 120000,
    parameter int unsigned DC_ON          = 6000000,
    parameter int unsigned GAP            = 1200000
) (
    input  logic              clk_x1,
    input  logic              rstn,
    input  logic              go,
    input  logic              abort,
    input  logic [CH_W-1:0]   sel,
    input  logic [AMT_W-1:0]  amount,
    output logic              step,
    output logic              dir,
    output logic [NUM_CH-1:0] dc_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CH_W-1:0]   cur_slot
);

    // -----------------------------------------------------------------------
    // Counter sizing. The position counter covers the furthest slot. The phase
    // timer covers the longest of the settle, motor-on and gap phases. Neither
    // counter can wrap.
    // -----------------------------------------------------------------------
    localparam int unsigned PosMax = (NUM_CH - 1) * STEPS_PER_SLOT;
    localparam int unsigned PosW   = $clog2(PosMax + 1);
    localparam int unsigned DivW   = $clog2(STEP_DIV + 1);
    localparam int unsigned TmrMax = (SETTLE > DC_ON) ? ((SETTLE > GAP) ? SETTLE : GAP)
                                                      : ((DC_ON > GAP) ? DC_ON : GAP);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [DivW-1:0] DivLast    = DivW'(STEP_DIV - 1);
    localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE - 1);
    localparam logic [TmrW-1:0] DcOnLast   = TmrW'(DC_ON - 1);
    localparam logic [TmrW-1:0] GapLast    = TmrW'(GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StSettle,
        StDispense,
        StGap,
        StDone
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              go_q;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [AMT_W-1:0]  item_q, item_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [CH_W-1:0]   cur_slot_q, cur_slot_d;
    logic              err_q, err_d;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic            go_edge;
    logic            sel_ok;
    logic [PosW-1:0] target_new;  // target of the request being offered
    logic [PosW-1:0] target_q;    // target of the latched request
    logic            step_fire;

    assign go_edge    = go & ~go_q;
    assign sel_ok     = 32'(sel) < NUM_CH;
    assign target_new = PosW'(sel) * PosW'(STEPS_PER_SLOT);
    assign target_q   = PosW'(sel_q) * PosW'(STEPS_PER_SLOT);

    // A pulse fires on the last cycle of each divider period. The move has
    // not yet reached its target when that happens.
    assign step_fire = (state_q == StMove) && (pos_q != target_q) && (div_q == DivLast);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        amt_d      = amt_q;
        item_d     = item_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        div_d      = div_q;
        tmr_d      = tmr_q;
        cur_slot_d = cur_slot_q;
        err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                // If abort and a go edge arrive together, abort wins and the
                // request is dropped.
                if (go_edge && !abort) begin
                    if (sel_ok) begin
                        sel_d   = sel;
                        amt_d   = amount;
                        dir_d   = target_new > pos_q;
                        div_d   = '0;
                        state_d = StMove;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StMove: begin
                if (pos_q == target_q) begin
                    tmr_d      = '0;
                    cur_slot_d = sel_q;
                    state_d    = StSettle;
                end else if (div_q == DivLast) begin
                    div_d = '0;
                    pos_d = dir_q ? (pos_q + PosW'(1)) : (pos_q - PosW'(1));
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end

            StSettle: begin
                if (tmr_q == SettleLast) begin
                    tmr_d   = '0;
                    item_d  = '0;
                    state_d = (amt_q == '0) ? StDone : StDispense;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end

            StDispense: begin
                if (tmr_q == DcOnLast) begin
                    tmr_d   = '0;
                    item_d  = item_q + AMT_W'(1);
                    // No gap after the last item.
                    state_d = ((item_q + AMT_W'(1)) == amt_q) ? StDone : StGap;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end

            StGap: begin
                if (tmr_q == GapLast) begin
                    tmr_d   = '0;
                    state_d = StDispense;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // An aborted operation drops straight to idle. A step that fires in
        // the abort cycle still reaches the motor, so pos_d keeps it. The
        // slot is not recorded, because the move never completed.
        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            cur_slot_d = cur_slot_q;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            go_q       <= 1'b0;
            sel_q      <= '0;
            amt_q      <= '0;
            item_q     <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            div_q      <= '0;
            tmr_q      <= '0;
            cur_slot_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go;
            sel_q      <= sel_d;
            amt_q      <= amt_d;
            item_q     <= item_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            tmr_q      <= tmr_d;
            cur_slot_q <= cur_slot_d;
            err_q      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. These are decoded from the state register, so reset clears
    // them at once without waiting for a clock edge.
    // -----------------------------------------------------------------------
    always_comb begin
        dc_en = '0;
        if (state_q == StDispense) begin
            dc_en = NUM_CH'(1) << sel_q;
        end
    end

    assign step     = step_fire;
    assign dir      = dir_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign err      = err_q;
    assign cur_slot = cur_slot_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dispense_sequencer
//
// Directed bench for dispense_sequencer with short timing parameters.
// A second instance, with NUM_CH=3, covers the invalid-slot error path.
// Outputs are sampled on the falling clock edge. Inputs change on that same
// edge, after sampling.
// ---------------------------------------------------------------------------
module tb_dispense_sequencer;

    localparam int unsigned StepDiv = 4;

    logic       clk_x1 = 1'b0;
    logic       rstn;
    logic       go, abort;
    logic [1:0] sel, amount;
    logic       step, dir, busy, done, err;
    logic [3:0] dc_en;
    logic [1:0] cur_slot;

    logic       go3, abort3;
    logic [1:0] sel3, amount3;
    logic       step3, dir3, busy3, done3, err3;
    logic [2:0] dc_en3;
    logic [1:0] cur_slot3;

    always #5 clk_x1 = ~clk_x1;

    dispense_sequencer #(
        .NUM_CH(4), .CH_W(2), .AMT_W(2), .STEP_DIV(StepDiv), .STEPS_PER_SLOT(3),
        .SETTLE(2), .DC_ON(8), .GAP(2)
    ) u_dut (
        .clk_x1(clk_x1), .rstn(rstn), .go(go), .abort(abort), .sel(sel), .amount(amount),
        .step(step), .dir(dir), .dc_en(dc_en), .busy(busy), .done(done), .err(err),
        .cur_slot(cur_slot)
    );

    dispense_sequencer #(
        .NUM_CH(3), .CH_W(2), .AMT_W(2), .STEP_DIV(StepDiv), .STEPS_PER_SLOT(3),
        .SETTLE(2), .DC_ON(8), .GAP(2)
    ) u_dut3 (
        .clk_x1(clk_x1), .rstn(rstn), .go(go3), .abort(abort3), .sel(sel3),
        .amount(amount3), .step(step3), .dir(dir3), .dc_en(dc_en3), .busy(busy3),
        .done(done3), .err(err3), .cur_slot(cur_slot3)
    );

    int errors = 0;
    int checks = 0;

    // Per-request statistics. t counts falling edges since the request edge.
    int t, nstep, ndc, ndone, nerr, nbusy;
    int first_step, bad_gap, bad_dir, first_dc, last_dc, bad_dc, done_t, last_step;
    int inv_bad = 0;
    int nerr3, nbusy3, nstep3;
    logic       exp_dir;
    logic [3:0] exp_dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        t = 0; nstep = 0; ndc = 0; ndone = 0; nerr = 0; nbusy = 0;
        first_step = -1; last_step = -1; bad_gap = 0; bad_dir = 0;
        first_dc = -1; last_dc = -1; bad_dc = 0; done_t = -1;
        nerr3 = 0; nbusy3 = 0; nstep3 = 0;
    endtask

    task automatic tick();
        @(negedge clk_x1);
        t++;
        if (step === 1'b1) begin
            if (last_step >= 0 && (t - last_step) != StepDiv) bad_gap++;
            if (first_step < 0) first_step = t;
            last_step = t;
            nstep++;
            if (dir !== exp_dir) bad_dir++;
        end
        if (dc_en !== 4'b0000) begin
            ndc++;
            if (first_dc < 0) first_dc = t;
            last_dc = t;
            if (dc_en !== exp_dc) bad_dc++;
        end
        if (done === 1'b1) begin ndone++; done_t = t; end
        if (err === 1'b1) nerr++;
        if (busy === 1'b1) nbusy++;
        if ($countones(dc_en) > 1 || (step === 1'b1 && dc_en !== 4'b0000)) inv_bad++;
        if (err3 === 1'b1) nerr3++;
        if (busy3 === 1'b1) nbusy3++;
        if (step3 === 1'b1) nstep3++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Presents a request. On return, t=1 is the first cycle after acceptance.
    task automatic req(input logic [1:0] s, input logic [1:0] a);
        clear_stats();
        sel = s; amount = a; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_t < 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; go = 1'b0; abort = 1'b0; sel = '0; amount = '0;
        go3 = 1'b0; abort3 = 1'b0; sel3 = '0; amount3 = '0;
        exp_dir = 1'b0; exp_dc = '0;
        clear_stats();
        run(3);

        // Reset state
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_dc_en", dc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cur_slot", cur_slot, 0);
        rstn = 1'b1;
        run(2);

        // Slot 0 -> 2, two items
        exp_dir = 1'b1; exp_dc = 4'b0100;
        req(2'd2, 2'd2);
        wait_done(100);
        check("t1_done_t", done_t, 46);
        check("t1_nstep", nstep, 6);
        check("t1_first_step", first_step, 4);
        check("t1_step_gap", bad_gap, 0);
        check("t1_dir", bad_dir, 0);
        check("t1_first_dc", first_dc, 28);
        check("t1_last_dc", last_dc, 45);
        check("t1_ndc", ndc, 16);
        check("t1_dc_val", bad_dc, 0);
        check("t1_nbusy", nbusy, 46);
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_cur_slot", cur_slot, 2);
        check("t1_ndone", ndone, 1);

        // Slot 2 -> 0, one item
        exp_dir = 1'b0; exp_dc = 4'b0001;
        req(2'd0, 2'd1);
        wait_done(100);
        check("t2_done_t", done_t, 36);
        check("t2_nstep", nstep, 6);
        check("t2_dir", bad_dir, 0);
        check("t2_step_gap", bad_gap, 0);
        check("t2_first_dc", first_dc, 28);
        check("t2_ndc", ndc, 8);
        check("t2_dc_val", bad_dc, 0);
        tick();
        check("t2_cur_slot", cur_slot, 0);

        // Same slot, zero items
        req(2'd0, 2'd0);
        wait_done(50);
        check("t3_done_t", done_t, 4);
        check("t3_nstep", nstep, 0);
        check("t3_ndc", ndc, 0);
        run(2);

        // Invalid slot on the NUM_CH=3 instance
        clear_stats();
        sel3 = 2'd3; amount3 = 2'd1; go3 = 1'b1;
        tick();
        go3 = 1'b0;
        run(10);
        check("t4_err_pulses", nerr3, 1);
        check("t4_busy", nbusy3, 0);
        check("t4_steps", nstep3, 0);

        // Abort after the fourth step of a move towards slot 3
        exp_dir = 1'b1; exp_dc = 4'b1000;
        req(2'd3, 2'd3);
        while (nstep < 4 && t < 100) tick();
        check("t5_abort_at", t, 16);
        abort = 1'b1;
        tick();
        check("t5_busy", busy, 0);
        check("t5_dc_en", dc_en, 0);
        abort = 1'b0;
        run(5);
        check("t5_nstep", nstep, 4);
        check("t5_ndone", ndone, 0);
        check("t5_cur_slot", cur_slot, 0);

        // Abort together with a go edge in idle drops the request
        clear_stats();
        sel = 2'd1; amount = 2'd0; go = 1'b1; abort = 1'b1;
        tick();
        go = 1'b0; abort = 1'b0;
        run(4);
        check("t5_drop_busy", nbusy, 0);

        // From 4 steps to slot 1 at 3 steps: a single backward step
        exp_dir = 1'b0;
        req(2'd1, 2'd0);
        wait_done(50);
        check("t5b_nstep", nstep, 1);
        check("t5b_dir", bad_dir, 0);
        check("t5b_done_t", done_t, 8);
        tick();
        check("t5b_cur_slot", cur_slot, 1);

        // A second go during dispense is ignored
        exp_dir = 1'b1; exp_dc = 4'b0100;
        req(2'd2, 2'd2);
        run(17);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done(100);
        check("t6_done_t", done_t, 34);
        check("t6_ndc", ndc, 16);
        run(20);
        check("t6_ndone", ndone, 1);
        check("t6_busy", busy, 0);

        // Reset in the middle of a dispense
        exp_dc = 4'b1000;
        req(2'd3, 2'd1);
        run(17);
        check("t6_pre_rst_dc", dc_en, 4'b1000);
        rstn = 1'b0;
        #1;
        check("t6_rst_dc_en", dc_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cur_slot", cur_slot, 0);
        run(2);
        rstn = 1'b1;
        tick();

        // The position restarts from 0: three forward steps to slot 1
        exp_dir = 1'b1;
        req(2'd1, 2'd0);
        wait_done(50);
        check("t6_post_nstep", nstep, 3);
        check("t6_post_dir", bad_dir, 0);
        check("t6_post_done_t", done_t, 16);
        tick();
        check("t6_post_cur_slot", cur_slot, 1);

        check("invariant", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
Parametrised dispense controller for the candy/snack machine. It accepts a channel select and an item count from the Raspberry Pi interface, plus a dispense strobe (candyflag). It steps the carousel stepper to the selected slot, then pulses that channel's DC motor once per item. It generalises the fixed 3-motor / 2-bit-amount top level to NUM_CH motor channels, a programmable count width, step-accurate position tracking, abort, and error reporting.

Parameters:
NUM_CH, 4, number of DC motor channels / carousel slots (2..8)
CH_W, 2, width of sel; must be >= clog2(NUM_CH)
AMT_W, 2, width of amount
STEP_DIV, 12000, clk_x1 cycles between step pulses (1 kHz at 12 MHz)
STEPS_PER_SLOT, 50, stepper steps between adjacent slots
SETTLE, 120000, cycles to wait after the last step before the motor turns on
DC_ON, 6000000, cycles the DC motor is on per item
GAP, 1200000, off cycles between consecutive items

Ports:
clk_x1  in  1  12 MHz system clock
rstn  in  1  asynchronous active-low reset
go  in  1  dispense request (candyflag); rising-edge detected internally
abort  in  1  level; cancels the current operation
sel  in  CH_W  target channel/slot
amount  in  AMT_W  items to dispense
step  out  1  stepper step pulse, 1 cycle wide
dir  out  1  stepper direction: 1 = increasing slot index
dc_en  out  NUM_CH  one-hot DC motor enables
busy  out  1  operation in progress
done  out  1  1-cycle completion pulse
err  out  1  1-cycle pulse on an invalid request
cur_slot  out  CH_W  slot at the last completed move

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE; step, dir, dc_en, busy, done, err, and cur_slot are 0; pos_steps=0; edge-detect register=0. All outputs go low immediately, including mid-move or mid-dispense.
- Request acceptance:
  - In IDLE, a go rising edge (go=1, previous sample 0) latches sel and amount.
  - go edges outside IDLE are ignored and are not queued.
  - If sel >= NUM_CH: err=1 for one cycle, stay in IDLE, busy stays 0.
  - Otherwise busy=1 from the next cycle.
- FSM states: IDLE -> MOVE -> SETTLE -> DISPENSE <-> GAP -> DONE -> IDLE.
- MOVE:
  - target = sel*STEPS_PER_SLOT.
  - On entry, dir = (target > pos_steps); dir is held through MOVE.
  - Divider counter: one step pulse every STEP_DIV cycles, the first at the STEP_DIV-th cycle in MOVE.
  - pos_steps is updated +/-1 on each pulse.
  - Leave MOVE on the cycle pos_steps reaches target.
  - If target == pos_steps on entry, MOVE lasts exactly 1 cycle with no pulses.
  - cur_slot <= sel on exit.
- SETTLE: SETTLE cycles, all motors off.
- Item counting:
  - If latched amount == 0, go from SETTLE directly to DONE with dc_en never asserted.
  - DISPENSE: dc_en[sel]=1, other bits 0, for exactly DC_ON cycles; then increment the item count.
  - If count == amount, go to DONE; otherwise go to GAP.
  - GAP: dc_en=0 for GAP cycles, then DISPENSE.
  - No GAP after the last item.
- DONE: done=1, busy=1 for one cycle; next cycle IDLE with busy=0.
- abort:
  - Sampled every cycle in any non-IDLE state. The next cycle: state=IDLE, dc_en=0, busy=0, no done pulse.
  - pos_steps keeps the steps actually taken. The next move computes from that value, so no homing is needed.
  - cur_slot is not updated on an aborted move.
  - abort in IDLE has no effect.
  - abort and go edge in the same IDLE cycle: abort wins, the request is dropped.
- dc_en is at most one-hot at all times. step and any dc_en are never high in the same cycle.
- Counter widths: sized by the bench-overridable parameters via clog2; no wrap is possible.

Test Plan:
Bench parameters: NUM_CH=4, STEP_DIV=4, STEPS_PER_SLOT=3, SETTLE=2, DC_ON=8, GAP=2.
- Reset, then go edge with sel=2, amount=2 -> dir=1, 6 step pulses at 4-cycle spacing; 2 settle cycles; dc_en=0100 for 8 cycles, 0 for 2, 0100 for 8; done pulse; cur_slot=2; busy low after.
- From slot 2, sel=0, amount=1 -> dir=0, 6 pulses, dc_en=0001 for 8 cycles, done, cur_slot=0.
- Same-slot request: sel=0, amount=0 -> no step pulses, no dc_en, done on the 4th cycle after acceptance (MOVE 1 + SETTLE 2 + DONE).
- With NUM_CH=3 override, sel=3 -> single err pulse, busy stays 0, no motion.
- sel=3, amount=3; assert abort after the 4th step pulse -> next cycle dc_en=0, busy=0, no done, cur_slot unchanged. A new request with sel=1 then issues exactly 1 pulse with dir=0 (from 4 steps to 3).
- Second go edge during DISPENSE, then rstn=0 mid-DISPENSE -> the second go is ignored (a single done only, with no reset); on reset, dc_en and busy clear immediately and pos_steps=0.
